// File: rtl/serial_pkg.sv
// Shared serial framing constants for serial_frame_rx and the PISO transmitter wrapper.
// States are 3 bits wide in every build so PARITY (SERIAL_FRAME_RX_PARITY_EN) fits.
package serial_pkg;

    localparam int unsigned DEFAULT_N            = 8;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 16;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_START  = 3'd1;
    localparam logic [STATE_W-1:0] ST_DATA   = 3'd2;
    localparam logic [STATE_W-1:0] ST_STOP   = 3'd3;
    localparam logic [STATE_W-1:0] ST_PARITY = 3'd4;

endpackage

// File: rtl/rx_line_sync.sv
// Two-flop synchronizer for the serial pin plus falling-edge detect on the synchronized line.
// Reset presets every flop to 1 so an idle-high line never reports a spurious edge.
module rx_line_sync (
    input  logic clk,
    input  logic reset_p,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rx;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rx_s = sync_q;
    assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Oversampling async-framed serial receiver (start, N data LSB-first, stop) with valid/ready output.
// Define SERIAL_FRAME_RX_PARITY_EN to add an even-parity bit between the data and stop bits.
module serial_frame_rx
    import serial_pkg::*;
#(
    parameter int unsigned N            = DEFAULT_N,
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic         clk,
    input  logic         reset_p,
    input  logic         rx,
    output logic [N-1:0] rx_data,
    output logic         rx_valid,
    input  logic         rx_ready,
    output logic         frame_err,
    output logic         overrun,
    output logic         parity_err
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(N + 1);

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    logic               rx_s;
    logic               fall;

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [N-1:0]       shreg_q, shreg_d;
    logic [N-1:0]       data_q,  data_d;
    logic               valid_q, valid_d;
    logic               ferr_q,  ferr_d;
    logic               ovr_q,   ovr_d;
    logic               good;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    logic               par_bad_q, par_bad_d;
    logic               perr_q,    perr_d;
`endif

    rx_line_sync u_sync (
        .clk     (clk),
        .reset_p (reset_p),
        .rx      (rx),
        .rx_s    (rx_s),
        .fall    (fall)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = valid_q & ~rx_ready;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        good    = 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_d    = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (fall) state_d = ST_START;
            end
            ST_START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_END) begin
                    cnt_d          = '0;
                    // right shift: the first (LSB) bit ends up in bit 0 after N samples
                    shreg_d        = shreg_q >> 1;
                    shreg_d[N-1]   = rx_s;
                    idx_d          = idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef SERIAL_FRAME_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == CNT_END) begin
                    cnt_d     = '0;
                    par_bad_d = ^shreg_q ^ rx_s;
                    perr_d    = ^shreg_q ^ rx_s;
                    state_d   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_q == CNT_END) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    if (!rx_s) begin
                        ferr_d = 1'b1;
                    end else begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
                        good = ~par_bad_q;
`else
                        good = 1'b1;
`endif
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        // A word being accepted this cycle frees the holding register for the new one
        if (good) begin
            if (!valid_q || rx_ready) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef SERIAL_FRAME_RX_PARITY_EN
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
        end
    end

    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed plus randomized bench for serial_frame_rx; expected words and pulse counts come from frame-level rules.
// Honours SERIAL_FRAME_RX_PARITY_EN the same way the design does.
module tb_serial_frame_rx;
    import serial_pkg::*;

    localparam int unsigned N = 8;
    localparam int unsigned C = 16;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    localparam int unsigned PBITS = 1;
`else
    localparam int unsigned PBITS = 0;
`endif
    localparam int unsigned LAT = (N + 1) * C + C / 2 + 3 + PBITS * C;

    logic         clk = 1'b0;
    logic         reset_p;
    logic         rx;
    logic         rx_ready;
    logic [N-1:0] rx_data;
    logic         rx_valid;
    logic         frame_err;
    logic         overrun;
    logic         parity_err;

    serial_frame_rx #(.N(N), .CLKS_PER_BIT(C)) dut (
        .clk        (clk),
        .reset_p    (reset_p),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pulse-cycle counts, rise times, delivered words, data stability
    int           fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, rise_cnt = 0, vcyc = 0;
    int           last_rise = 0, stab_bad = 0;
    logic         prev_v = 1'b0, prev_hs = 1'b0;
    logic [N-1:0] prev_d = '0;
    logic [N-1:0] got[$];

    always @(negedge clk) begin
        if (frame_err)  fe_cnt++;
        if (overrun)    ov_cnt++;
        if (parity_err) pe_cnt++;
        if (rx_valid)   vcyc++;
        if (rx_valid && !prev_v) begin
            rise_cnt++;
            last_rise = cyc;
        end
        if (rx_valid && prev_v && !prev_hs && rx_data !== prev_d) stab_bad++;
        if (rx_valid && rx_ready) got.push_back(rx_data);
        prev_hs = rx_valid && rx_ready;
        prev_v  = rx_valid;
        prev_d  = rx_data;
    end

    int n_assert = 0;
    int n_fail   = 0;
    int gi       = 0;
    int start_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        tick(C);
    endtask

    task automatic send_frame(input logic [N-1:0] d, input logic stop_b, input logic par_ok);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < N; i++) drive_bit(d[i]);
`ifdef SERIAL_FRAME_RX_PARITY_EN
        drive_bit(par_ok ? ^d : ~^d);
`endif
        drive_bit(stop_b);
        rx = 1'b1;
    endtask

    task automatic expect_word(input string tag, input logic [N-1:0] exp);
        check({tag, " delivered"}, 32'(got.size() > gi), 32'd1);
        if (got.size() > gi) begin
            check(tag, 32'(got[gi]), 32'(exp));
            gi++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r0, v0, f0, o0, p0, n_rand, efe, epe;
        logic [N-1:0] exp_q[$];
        logic [N-1:0] d;
        logic         stop_b, pok;

        reset_p  = 1'b1;
        rx       = 1'b1;
        rx_ready = 1'b0;
        tick(3);
        check("reset rx_valid",   32'(rx_valid),   32'd0);
        check("reset rx_data",    32'(rx_data),    32'd0);
        check("reset frame_err",  32'(frame_err),  32'd0);
        check("reset overrun",    32'(overrun),    32'd0);
        check("reset parity_err", 32'(parity_err), 32'd0);

        reset_p = 1'b0;
        tick(200);
        check("idle no valid", 32'(rise_cnt), 32'd0);
        check("idle no ferr",  32'(fe_cnt),   32'd0);

        // 0xA5 with consumer ready: one-cycle valid at the nominal latency
        rx_ready = 1'b1;
        r0 = rise_cnt; v0 = vcyc;
        send_frame(8'hA5, 1'b1, 1'b1);
        tick(4);
        check("A5 rises",   32'(rise_cnt - r0),         32'd1);
        check("A5 latency", 32'(last_rise - start_cyc), 32'(LAT));
        check("A5 width",   32'(vcyc - v0),             32'd1);
        expect_word("A5 data", 8'hA5);

        // Held word, then overrun from a second frame
        rx_ready = 1'b0;
        send_frame(8'h3C, 1'b1, 1'b1);
        tick(4);
        check("3C valid", 32'(rx_valid), 32'd1);
        check("3C data",  32'(rx_data),  32'h3C);
        o0 = ov_cnt;
        send_frame(8'h81, 1'b1, 1'b1);
        tick(4);
        check("81 overrun pulse", 32'(ov_cnt - o0), 32'd1);
        check("81 valid held",    32'(rx_valid),    32'd1);
        check("81 data held",     32'(rx_data),     32'h3C);
        rx_ready = 1'b1;
        tick(1);
        check("3C valid cleared", 32'(rx_valid), 32'd0);
        expect_word("3C accepted", 8'h3C);

        // Bad stop bit, then a good frame
        f0 = fe_cnt; r0 = rise_cnt;
        send_frame(8'h55, 1'b0, 1'b1);
        tick(4);
        check("55 frame_err pulse", 32'(fe_cnt - f0),   32'd1);
        check("55 no valid",        32'(rise_cnt - r0), 32'd0);
        tick(5);
        send_frame(8'h0F, 1'b1, 1'b1);
        tick(4);
        expect_word("0F data", 8'h0F);

        // 5-cycle glitch, then a frame starting 12 cycles after the glitch began
        f0 = fe_cnt; r0 = rise_cnt;
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        tick(7);
        send_frame(8'h5A, 1'b1, 1'b1);
        tick(4);
        check("glitch no ferr",    32'(fe_cnt - f0),           32'd0);
        check("glitch one rise",   32'(rise_cnt - r0),         32'd1);
        check("post-glitch lat",   32'(last_rise - start_cyc), 32'(LAT));
        expect_word("5A data", 8'h5A);

        // Reset in data bit 4 of 0xFF while a word is pending
        rx_ready = 1'b0;
        send_frame(8'h6B, 1'b1, 1'b1);
        tick(4);
        check("6B pending", 32'(rx_valid), 32'd1);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        tick(3);
        reset_p = 1'b1;
        #1;
        check("midreset rx_valid", 32'(rx_valid),  32'd0);
        check("midreset rx_data",  32'(rx_data),   32'd0);
        check("midreset ferr",     32'(frame_err), 32'd0);
        tick(3);
        reset_p = 1'b0;
        tick(20);
        rx_ready = 1'b1;
        send_frame(8'h12, 1'b1, 1'b1);
        tick(4);
        expect_word("12 after reset", 8'h12);

`ifdef SERIAL_FRAME_RX_PARITY_EN
        p0 = pe_cnt; r0 = rise_cnt;
        send_frame(8'h07, 1'b1, 1'b1);
        tick(4);
        expect_word("07 parity ok", 8'h07);
        check("07 no parity_err", 32'(pe_cnt - p0), 32'd0);
        p0 = pe_cnt; r0 = rise_cnt;
        send_frame(8'h07, 1'b1, 1'b0);
        tick(4);
        check("07 parity_err pulse", 32'(pe_cnt - p0),   32'd1);
        check("07 bad no valid",     32'(rise_cnt - r0), 32'd0);
`endif

        // Randomized frames: delivered iff stop is high and parity (if any) is even
        f0 = fe_cnt; o0 = ov_cnt; p0 = pe_cnt;
        efe = 0; epe = 0;
        n_rand = gi;
        for (int k = 0; k < 24; k++) begin
            d      = N'($urandom);
            stop_b = ($urandom_range(3) != 0);
`ifdef SERIAL_FRAME_RX_PARITY_EN
            pok    = ($urandom_range(3) != 0);
`else
            pok    = 1'b1;
`endif
            if (stop_b && pok) exp_q.push_back(d);
            if (!stop_b) efe++;
            if (!pok)    epe++;
            send_frame(d, stop_b, pok);
            tick($urandom_range(0, 10));
        end
        tick(4);
        check("rand frame_err count",  32'(fe_cnt - f0), 32'(efe));
        check("rand parity_err count", 32'(pe_cnt - p0), 32'(epe));
        check("rand overrun count",    32'(ov_cnt - o0), 32'd0);
        check("rand word count",       32'(got.size() - n_rand), 32'(exp_q.size()));
        foreach (exp_q[j]) expect_word("rand data", exp_q[j]);

        check("data stable while valid", 32'(stab_bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
